// File: rtl/ram_image_loader.sv
// ram_image_loader
//   Copies a memory image from a synchronous image ROM into the SLC-3 RAM after
//   reset or on a Reload request. It can zero-fill the RAM tail and can read the
//   image back for comparison. While loading, it owns the RAM port and holds the
//   CPU. In RUN, it passes the CPU RAM port straight through.
//
// Ports
//   Clk, Reset_n        clock (rising edge), asynchronous active-low reset
//   Reload              pulse in RUN restarts the load sequence
//   img_addr/img_data   image ROM port (data valid one cycle after address)
//   cpu_*               CPU RAM request, honoured only in RUN
//   ram_*               RAM port (ram_q valid one cycle after address/read)
//   cpu_hold, done      CPU stall and load-complete flags
//   err, err_count,     verify result: any mismatch, saturating count,
//   err_addr            address of the first mismatch
module ram_image_loader #(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 10,
  parameter int INIT_WORDS = 256,
  parameter int ZERO_FILL  = 0,
  parameter int VERIFY     = 1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Reload,
  output logic [ADDR_W-1:0] img_addr,
  input  logic [DATA_W-1:0] img_data,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic              cpu_oe,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_wren,
  output logic              ram_rden,
  input  logic [DATA_W-1:0] ram_q,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [7:0]        err_count,
  output logic [ADDR_W-1:0] err_addr
);

  // One spare counter bit so that INIT_WORDS = 2^ADDR_W ends without wrapping.
  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] K_ONE  = CW'(1);
  localparam logic [CW-1:0] K_INIT = CW'(INIT_WORDS);
  localparam logic [CW-1:0] K_LAST = CW'(INIT_WORDS - 1);
  localparam logic [CW-1:0] K_TOP  = CW'((1 << ADDR_W) - 1);
  localparam bit DO_FILL   = (ZERO_FILL != 0) && (INIT_WORDS < (1 << ADDR_W));
  localparam bit DO_VERIFY = (VERIFY != 0);

  localparam logic [2:0] S_LOAD   = 3'd0;
  localparam logic [2:0] S_FILL   = 3'd1;
  localparam logic [2:0] S_VERIFY = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_RUN    = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CW-1:0]     k_q, k_d;
  logic              err_q, err_d;
  logic [7:0]        err_count_q, err_count_d;
  logic [ADDR_W-1:0] err_addr_q, err_addr_d;

  logic [ADDR_W-1:0] k_lo;
  logic [ADDR_W-1:0] prev_addr;
  logic              cmp_en;
  logic              mismatch;

  assign k_lo = k_q[ADDR_W-1:0];
  // Address issued one cycle ago. This is used for pipelined writes and
  // read-back compares. At k = 2^ADDR_W, it wraps correctly to the top address.
  assign prev_addr = k_lo - ADDR_W'(1);

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    err_d       = err_q;
    err_count_d = err_count_q;
    err_addr_d  = err_addr_q;
    cmp_en      = 1'b0;

    case (state_q)
      S_LOAD: begin
        // At k == INIT_WORDS, nothing is issued. Only the last pipelined write completes.
        if (k_q == K_INIT) begin
          if (DO_FILL) begin
            state_d = S_FILL;
            k_d     = K_INIT;
          end else begin
            state_d = DO_VERIFY ? S_VERIFY : S_RUN;
            k_d     = '0;
          end
        end else begin
          k_d = k_q + K_ONE;
        end
      end
      S_FILL: begin
        if (k_q == K_TOP) begin
          state_d = DO_VERIFY ? S_VERIFY : S_RUN;
          k_d     = '0;
        end else begin
          k_d = k_q + K_ONE;
        end
      end
      S_VERIFY: begin
        cmp_en = (k_q != '0);
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
          k_d     = K_INIT;
        end else begin
          k_d = k_q + K_ONE;
        end
      end
      S_DRAIN: begin
        cmp_en  = 1'b1;
        state_d = S_RUN;
        k_d     = '0;
      end
      S_RUN: begin
        if (Reload) begin
          state_d = S_LOAD;
          k_d     = '0;
        end
      end
      default: begin
        state_d = S_LOAD;
        k_d     = '0;
      end
    endcase

    mismatch = cmp_en && (ram_q != img_data);
    if (mismatch) begin
      err_d = 1'b1;
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
      if (!err_q) err_addr_d = prev_addr;
    end

    if ((state_q == S_RUN) && Reload) begin
      err_d       = 1'b0;
      err_count_d = '0;
      err_addr_d  = '0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_LOAD;
      k_q         <= '0;
      err_q       <= 1'b0;
      err_count_q <= '0;
      err_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
      err_addr_q  <= err_addr_d;
    end
  end

  // All outputs are decoded from registered state. Asynchronous reset therefore
  // reaches them immediately.
  always_comb begin
    img_addr  = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_wren  = 1'b0;
    ram_rden  = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_LOAD: begin
        if (k_q < K_INIT) img_addr = k_lo;
        if (k_q != '0) begin
          ram_wren  = 1'b1;
          ram_addr  = prev_addr;
          ram_wdata = img_data;
        end
      end
      S_FILL: begin
        ram_wren = 1'b1;
        ram_addr = k_lo;
      end
      S_VERIFY: begin
        img_addr = k_lo;
        ram_addr = k_lo;
        ram_rden = 1'b1;
      end
      S_RUN: begin
        done      = 1'b1;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        ram_wren  = cpu_we;
        ram_rden  = cpu_oe;
      end
      default: ;
    endcase
  end

  assign cpu_hold  = ~done;
  assign err       = err_q;
  assign err_count = err_count_q;
  assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_ram_image_loader.sv
// Testbench for ram_image_loader. Four instances with different parameter sets
// share the clock and CPU stimulus. Each instance has its own reset. Behavioural
// ROM/RAM models sit beside each instance. Some RAM models corrupt read data to
// exercise the error reporting.
module tb_ram_image_loader;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;

  logic        Reload = 1'b0;
  logic [9:0]  cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic        cpu_we = 1'b0;
  logic        cpu_oe = 1'b0;
  logic        rst0 = 1'b0, rst1 = 1'b0, rst2 = 1'b0, rst3 = 1'b0;

  // u0: INIT=4, no verify. u1: INIT=4, verify, RAM reads 0xDEAD at address 2.
  // u2: ADDR_W=3, INIT=3, zero fill. u3: INIT=300, verify, every read corrupted.
  logic [9:0]  img_addr0, ram_addr0, err_addr0;
  logic [15:0] img_data0, ram_wdata0, ram_q0;
  logic        ram_wren0, ram_rden0, cpu_hold0, done0, err0;
  logic [7:0]  err_count0;

  logic [9:0]  img_addr1, ram_addr1, err_addr1;
  logic [15:0] img_data1, ram_wdata1, ram_q1;
  logic        ram_wren1, ram_rden1, cpu_hold1, done1, err1;
  logic [7:0]  err_count1;

  logic [2:0]  img_addr2, ram_addr2, err_addr2;
  logic [15:0] img_data2, ram_wdata2, ram_q2;
  logic        ram_wren2, ram_rden2, cpu_hold2, done2, err2;
  logic [7:0]  err_count2;

  logic [9:0]  img_addr3, ram_addr3, err_addr3;
  logic [15:0] img_data3, ram_wdata3, ram_q3;
  logic        ram_wren3, ram_rden3, cpu_hold3, done3, err3;
  logic [7:0]  err_count3;

  ram_image_loader #(.DATA_W(16), .ADDR_W(10), .INIT_WORDS(4), .ZERO_FILL(0), .VERIFY(0)) u0 (
    .Clk(Clk), .Reset_n(rst0), .Reload(Reload), .img_addr(img_addr0), .img_data(img_data0),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_oe(cpu_oe),
    .ram_addr(ram_addr0), .ram_wdata(ram_wdata0), .ram_wren(ram_wren0), .ram_rden(ram_rden0),
    .ram_q(ram_q0), .cpu_hold(cpu_hold0), .done(done0), .err(err0), .err_count(err_count0),
    .err_addr(err_addr0));

  ram_image_loader #(.DATA_W(16), .ADDR_W(10), .INIT_WORDS(4), .ZERO_FILL(0), .VERIFY(1)) u1 (
    .Clk(Clk), .Reset_n(rst1), .Reload(Reload), .img_addr(img_addr1), .img_data(img_data1),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_oe(cpu_oe),
    .ram_addr(ram_addr1), .ram_wdata(ram_wdata1), .ram_wren(ram_wren1), .ram_rden(ram_rden1),
    .ram_q(ram_q1), .cpu_hold(cpu_hold1), .done(done1), .err(err1), .err_count(err_count1),
    .err_addr(err_addr1));

  ram_image_loader #(.DATA_W(16), .ADDR_W(3), .INIT_WORDS(3), .ZERO_FILL(1), .VERIFY(1)) u2 (
    .Clk(Clk), .Reset_n(rst2), .Reload(Reload), .img_addr(img_addr2), .img_data(img_data2),
    .cpu_addr(cpu_addr[2:0]), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_oe(cpu_oe),
    .ram_addr(ram_addr2), .ram_wdata(ram_wdata2), .ram_wren(ram_wren2), .ram_rden(ram_rden2),
    .ram_q(ram_q2), .cpu_hold(cpu_hold2), .done(done2), .err(err2), .err_count(err_count2),
    .err_addr(err_addr2));

  ram_image_loader #(.DATA_W(16), .ADDR_W(10), .INIT_WORDS(300), .ZERO_FILL(0), .VERIFY(1)) u3 (
    .Clk(Clk), .Reset_n(rst3), .Reload(Reload), .img_addr(img_addr3), .img_data(img_data3),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_oe(cpu_oe),
    .ram_addr(ram_addr3), .ram_wdata(ram_wdata3), .ram_wren(ram_wren3), .ram_rden(ram_rden3),
    .ram_q(ram_q3), .cpu_hold(cpu_hold3), .done(done3), .err(err3), .err_count(err_count3),
    .err_addr(err_addr3));

  function automatic logic [15:0] rom4(input logic [9:0] a);
    case (a)
      10'd0:   rom4 = 16'h1111;
      10'd1:   rom4 = 16'h2222;
      10'd2:   rom4 = 16'h3333;
      10'd3:   rom4 = 16'h4444;
      default: rom4 = 16'h0000;
    endcase
  endfunction

  // Image ROMs (synchronous, one-cycle latency)
  always @(posedge Clk) img_data0 <= rom4(img_addr0);
  always @(posedge Clk) img_data1 <= rom4(img_addr1);
  always @(posedge Clk) img_data2 <= (img_addr2 < 3'd3) ? 16'hA001 + 16'(img_addr2) : 16'h0000;
  always @(posedge Clk) img_data3 <= 16'(img_addr3);

  // RAMs (synchronous write, one-cycle read)
  logic [15:0] mem0 [0:1023];
  logic [15:0] mem1 [0:1023];
  logic [15:0] mem2 [0:7];
  logic [15:0] mem3 [0:1023];

  always @(posedge Clk) begin
    if (ram_wren0) mem0[ram_addr0] <= ram_wdata0;
    if (ram_rden0) ram_q0 <= mem0[ram_addr0];
  end
  always @(posedge Clk) begin
    if (ram_wren1) mem1[ram_addr1] <= ram_wdata1;
    if (ram_rden1) ram_q1 <= (ram_addr1 == 10'd2) ? 16'hDEAD : mem1[ram_addr1];
  end
  always @(posedge Clk) begin
    if (ram_wren2) mem2[ram_addr2] <= ram_wdata2;
    if (ram_rden2) ram_q2 <= mem2[ram_addr2];
  end
  always @(posedge Clk) begin
    if (ram_wren3) mem3[ram_addr3] <= ram_wdata3;
    if (ram_rden3) ram_q3 <= ~mem3[ram_addr3];
  end

  task automatic test_reset;
    // CPU activity during reset must not reach the RAM.
    cpu_addr = 10'd7; cpu_wdata = 16'h1234; cpu_we = 1'b1; cpu_oe = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    if (img_addr0 !== 10'd0) begin $display("FAIL reset_img_addr got %h exp 0", img_addr0); fails++; end
    tests++;
    if (ram_wren0 !== 1'b0) begin $display("FAIL reset_ram_wren got %b exp 0", ram_wren0); fails++; end
    tests++;
    if (ram_rden0 !== 1'b0) begin $display("FAIL reset_ram_rden got %b exp 0", ram_rden0); fails++; end
    tests++;
    if (ram_addr0 !== 10'd0) begin $display("FAIL reset_ram_addr got %h exp 0", ram_addr0); fails++; end
    tests++;
    if (ram_wdata0 !== 16'h0) begin $display("FAIL reset_ram_wdata got %h exp 0", ram_wdata0); fails++; end
    tests++;
    if (cpu_hold0 !== 1'b1) begin $display("FAIL reset_cpu_hold got %b exp 1", cpu_hold0); fails++; end
    tests++;
    if (done0 !== 1'b0) begin $display("FAIL reset_done got %b exp 0", done0); fails++; end
    tests++;
    if (err0 !== 1'b0) begin $display("FAIL reset_err got %b exp 0", err0); fails++; end
    tests++;
    if (err_count0 !== 8'd0) begin $display("FAIL reset_err_count got %0d exp 0", err_count0); fails++; end
    tests++;
    if (err_addr0 !== 10'd0) begin $display("FAIL reset_err_addr got %h exp 0", err_addr0); fails++; end
    tests++;
    cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_oe = 1'b0;
  endtask

  task automatic test_load;
    logic        exp_wren;
    logic [9:0]  exp_addr;
    logic [15:0] exp_data;
    @(negedge Clk) rst0 = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      if (c > 0) begin @(posedge Clk); #1; end
      exp_wren = (c >= 1) && (c <= 4);
      exp_addr = exp_wren ? 10'(c - 1) : 10'd0;
      exp_data = exp_wren ? rom4(10'(c - 1)) : 16'h0;
      if (ram_wren0 !== exp_wren) begin $display("FAIL load_wren c=%0d got %b exp %b", c, ram_wren0, exp_wren); fails++; end
      tests++;
      if (ram_addr0 !== exp_addr) begin $display("FAIL load_addr c=%0d got %h exp %h", c, ram_addr0, exp_addr); fails++; end
      tests++;
      if (ram_wdata0 !== exp_data) begin $display("FAIL load_wdata c=%0d got %h exp %h", c, ram_wdata0, exp_data); fails++; end
      tests++;
      if (ram_rden0 !== 1'b0) begin $display("FAIL load_rden c=%0d got %b exp 0", c, ram_rden0); fails++; end
      tests++;
      if (done0 !== (c >= 5)) begin $display("FAIL load_done c=%0d got %b exp %b", c, done0, c >= 5); fails++; end
      tests++;
      if (cpu_hold0 !== (c < 5)) begin $display("FAIL load_hold c=%0d got %b exp %b", c, cpu_hold0, c < 5); fails++; end
      tests++;
      if (c <= 3) begin
        if (img_addr0 !== 10'(c)) begin $display("FAIL load_img_addr c=%0d got %h exp %h", c, img_addr0, 10'(c)); fails++; end
        tests++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      if (mem0[i] !== rom4(10'(i))) begin $display("FAIL load_mem[%0d] got %h exp %h", i, mem0[i], rom4(10'(i))); fails++; end
      tests++;
    end
  endtask

  task automatic test_verify_error;
    int done_cyc = -1;
    int both = 0;
    @(negedge Clk) rst1 = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge Clk); #1;
      if (ram_wren1 && ram_rden1) both++;
      if (done1) begin done_cyc = c; break; end
    end
    if (done_cyc != 10) begin $display("FAIL verify_done_cycle got %0d exp 10", done_cyc); fails++; end
    tests++;
    if (both != 0) begin $display("FAIL verify_wren_rden_overlap got %0d exp 0", both); fails++; end
    tests++;
    if (err1 !== 1'b1) begin $display("FAIL verify_err got %b exp 1", err1); fails++; end
    tests++;
    if (err_count1 !== 8'd1) begin $display("FAIL verify_err_count got %0d exp 1", err_count1); fails++; end
    tests++;
    if (err_addr1 !== 10'd2) begin $display("FAIL verify_err_addr got %h exp 2", err_addr1); fails++; end
    tests++;
    if (cpu_hold1 !== 1'b0) begin $display("FAIL verify_cpu_hold got %b exp 0", cpu_hold1); fails++; end
    tests++;
  endtask

  task automatic test_zero_fill;
    logic [2:0]  wa [$];
    logic [15:0] wd [$];
    logic [15:0] exp_d;
    int done_cyc = -1;
    int extra = 0;
    @(negedge Clk) rst2 = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge Clk); #1;
      if (done2) begin done_cyc = c; break; end
      if (ram_wren2) begin wa.push_back(ram_addr2); wd.push_back(ram_wdata2); end
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge Clk); #1;
      if (ram_wren2) extra++;
    end
    if (done_cyc != 13) begin $display("FAIL fill_done_cycle got %0d exp 13", done_cyc); fails++; end
    tests++;
    if (wa.size() != 8) begin $display("FAIL fill_write_count got %0d exp 8", wa.size()); fails++; end
    tests++;
    if (extra != 0) begin $display("FAIL fill_extra_writes got %0d exp 0", extra); fails++; end
    tests++;
    for (int i = 0; i < 8; i++) begin
      exp_d = (i < 3) ? 16'hA001 + 16'(i) : 16'h0000;
      if (i >= wa.size()) begin
        $display("FAIL fill_write[%0d] got none exp addr %0d", i, i); fails++;
      end else if (wa[i] !== 3'(i) || wd[i] !== exp_d) begin
        $display("FAIL fill_write[%0d] got %0d:%h exp %0d:%h", i, wa[i], wd[i], i, exp_d); fails++;
      end
      tests++;
    end
    if (err2 !== 1'b0 || err_addr2 !== 3'd0 || cpu_hold2 !== 1'b0) begin
      $display("FAIL fill_status got err=%b addr=%0d hold=%b exp 0/0/0", err2, err_addr2, cpu_hold2); fails++;
    end
    tests++;
  endtask

  task automatic test_saturation;
    int done_cyc = -1;
    @(negedge Clk) rst3 = 1'b1;
    for (int c = 1; c <= 1000; c++) begin
      @(posedge Clk); #1;
      if (done3) begin done_cyc = c; break; end
    end
    if (done_cyc != 602) begin $display("FAIL sat_done_cycle got %0d exp 602", done_cyc); fails++; end
    tests++;
    if (err_count3 !== 8'd255) begin $display("FAIL sat_err_count got %0d exp 255", err_count3); fails++; end
    tests++;
    if (err_addr3 !== 10'd0) begin $display("FAIL sat_err_addr got %h exp 0", err_addr3); fails++; end
    tests++;
    if (err3 !== 1'b1 || cpu_hold3 !== 1'b0) begin $display("FAIL sat_status got err=%b hold=%b exp 1/0", err3, cpu_hold3); fails++; end
    tests++;
  endtask

  task automatic test_passthrough_reload;
    int d0 = -1;
    int d1 = -1;
    @(negedge Clk);
    cpu_addr = 10'd5; cpu_wdata = 16'hBEEF; cpu_we = 1'b1; cpu_oe = 1'b0;
    #1;
    if (ram_addr0 !== 10'd5 || ram_wdata0 !== 16'hBEEF || ram_wren0 !== 1'b1 || ram_rden0 !== 1'b0) begin
      $display("FAIL pass_write got %h/%h/%b/%b exp 005/beef/1/0", ram_addr0, ram_wdata0, ram_wren0, ram_rden0); fails++;
    end
    tests++;
    @(negedge Clk);
    cpu_addr = 10'd1; cpu_wdata = 16'h5555; Reload = 1'b1;
    #1;
    if (ram_addr0 !== 10'd1 || ram_wdata0 !== 16'h5555 || ram_wren0 !== 1'b1) begin
      $display("FAIL pass_reload_cycle got %h/%h/%b exp 001/5555/1", ram_addr0, ram_wdata0, ram_wren0); fails++;
    end
    tests++;
    if (err_count1 !== 8'd1) begin $display("FAIL pre_reload_err_count got %0d exp 1", err_count1); fails++; end
    tests++;
    @(posedge Clk); #1;
    Reload = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    if (cpu_hold0 !== 1'b1 || done0 !== 1'b0 || ram_wren0 !== 1'b0) begin
      $display("FAIL reload_u0 got hold=%b done=%b wren=%b exp 1/0/0", cpu_hold0, done0, ram_wren0); fails++;
    end
    tests++;
    if (err1 !== 1'b0 || err_count1 !== 8'd0 || err_addr1 !== 10'd0 || done1 !== 1'b0) begin
      $display("FAIL reload_u1_clear got err=%b cnt=%0d addr=%h done=%b exp 0/0/0/0", err1, err_count1, err_addr1, done1); fails++;
    end
    tests++;
    for (int c = 1; c <= 40; c++) begin
      @(posedge Clk); #1;
      if (done0 && d0 < 0) d0 = c;
      if (done1) begin d1 = c; break; end
    end
    if (d0 != 5) begin $display("FAIL reload_u0_done_cycle got %0d exp 5", d0); fails++; end
    tests++;
    if (d1 != 10) begin $display("FAIL reload_u1_done_cycle got %0d exp 10", d1); fails++; end
    tests++;
    if (mem0[1] !== 16'h2222) begin $display("FAIL reload_rewrite got %h exp 2222", mem0[1]); fails++; end
    tests++;
    if (mem0[5] !== 16'hBEEF) begin $display("FAIL pass_mem5 got %h exp beef", mem0[5]); fails++; end
    tests++;
    if (err_count1 !== 8'd1 || err_addr1 !== 10'd2) begin
      $display("FAIL reverify got cnt=%0d addr=%h exp 1/002", err_count1, err_addr1); fails++;
    end
    tests++;
  endtask

  task automatic test_reset_abort;
    logic        exp_wren;
    logic [9:0]  exp_addr;
    logic [15:0] exp_data;
    @(negedge Clk) rst0 = 1'b0;
    @(negedge Clk) rst0 = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    if (img_addr0 !== 10'd2 || ram_wren0 !== 1'b1 || ram_addr0 !== 10'd1) begin
      $display("FAIL abort_setup got img=%h wren=%b addr=%h exp 002/1/001", img_addr0, ram_wren0, ram_addr0); fails++;
    end
    tests++;
    #2 rst0 = 1'b0;
    #1;
    if (img_addr0 !== '0 || ram_addr0 !== '0 || ram_wdata0 !== '0 || ram_wren0 !== 1'b0 || ram_rden0 !== 1'b0) begin
      $display("FAIL abort_port got img=%h addr=%h wd=%h wren=%b rden=%b exp all 0",
               img_addr0, ram_addr0, ram_wdata0, ram_wren0, ram_rden0); fails++;
    end
    tests++;
    if (cpu_hold0 !== 1'b1 || done0 !== 1'b0 || err0 !== 1'b0 || err_count0 !== 8'd0 || err_addr0 !== '0) begin
      $display("FAIL abort_status got hold=%b done=%b err=%b cnt=%0d addr=%h exp 1/0/0/0/0",
               cpu_hold0, done0, err0, err_count0, err_addr0); fails++;
    end
    tests++;
    @(negedge Clk) rst0 = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      if (c > 0) begin @(posedge Clk); #1; end
      exp_wren = (c >= 1) && (c <= 4);
      exp_addr = exp_wren ? 10'(c - 1) : 10'd0;
      exp_data = exp_wren ? rom4(10'(c - 1)) : 16'h0;
      if (ram_wren0 !== exp_wren || ram_addr0 !== exp_addr || ram_wdata0 !== exp_data || done0 !== (c == 5)) begin
        $display("FAIL abort_reload c=%0d got %b/%h/%h/%b exp %b/%h/%h/%b", c, ram_wren0, ram_addr0,
                 ram_wdata0, done0, exp_wren, exp_addr, exp_data, c == 5); fails++;
      end
      tests++;
    end
  endtask

  initial begin
    test_reset;
    test_load;
    test_verify_error;
    test_zero_fill;
    test_saturation;
    test_passthrough_reload;
    test_reset_abort;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
